rr_bus_arbiter8: RTL and testbench

//  Round-robin arbiter that shares one 32-bit result bus among 8 requesters.

---
 rtl/rr_bus_arbiter8_pkg.sv | 13 +
 rtl/rr_bus_arbiter8_pick.sv | 33 +++
 rtl/rr_bus_arbiter8.sv | 94 +++++++++
 tb/tb_rr_bus_arbiter8.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_bus_arbiter8_pkg.sv
// Shared constants and FSM encoding for the
// 8-way round-robin bus arbiter.
package rr_bus_arbiter8_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_bus_arbiter8_pick.sv
// rr_pick8: circular priority picker, returns the
// first set request bit strictly after ptr.
module rr_pick8
  import rr_bus_arbiter8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic             found;
  logic [SEL_W:0]   pos;
  logic [SEL_W-1:0] cand;

  assign any = |req;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos  = {1'b0, ptr} + (SEL_W+1)'(k);
      cand = pos[SEL_W-1:0];
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_bus_arbiter8.sv
// Round-robin owner of the shared result bus; holds
// the mux select for a whole burst.
module rr_bus_arbiter8
  import rr_bus_arbiter8_pkg::*;
#(
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] last,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt,
  output logic             out_valid,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(MAX_BEATS - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             xfer;
  logic             final_beat;
  logic             rel;

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign sel        = sel_q;
  assign gnt        = gnt_q;
  assign busy       = (state_q == ST_GRANT);
  assign out_valid  = busy & req[sel_q];
  assign xfer       = out_valid & out_ready;
  assign final_beat = last[sel_q] | (cnt_q == CNT_LAST);
  // a dropped request releases without counting a beat
  assign rel        = ~req[sel_q] | (xfer & final_beat);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_GRANT;
          sel_d   = pick_idx;
          gnt_d   = N_REQ'(1) << pick_idx;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (rel) begin
          state_d = ST_IDLE;
          ptr_d   = sel_q;
          gnt_d   = '0;
        end else if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= SEL_W'(N_REQ - 1);
      sel_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rr_bus_arbiter8.sv
// Testbench for rr_bus_arbiter8: vector table, directed
// corner sequences and a randomized reference model.
module tb_rr_bus_arbiter8;

  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] last;
  logic       out_ready;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       out_valid;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  rr_bus_arbiter8 #(
    .MAX_BEATS (MAXB),
    .CNT_W     (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .last      (last),
    .out_ready (out_ready),
    .sel       (sel),
    .gnt       (gnt),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic [7:0] last;
    logic       rdy;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       busy;
    logic       valid;
  } vec_t;

  vec_t tbl[17];

  // reference model state
  int m_busy, m_sel, m_ptr, m_cnt;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic chk_out(string nm, logic [2:0] es,
                         logic [7:0] eg, logic eb,
                         logic ev);
    chk({nm, ".sel"}, 32'(sel), 32'(es));
    chk({nm, ".gnt"}, 32'(gnt), 32'(eg));
    chk({nm, ".busy"}, 32'(busy), 32'(eb));
    chk({nm, ".valid"}, 32'(out_valid), 32'(ev));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // spec-level model: one call per clock edge
  task automatic model_step(logic [7:0] r,
                            logic [7:0] l, logic rd);
    int w;
    bit f;
    if (m_busy == 0) begin
      if (r != 0) begin
        f = 0;
        w = 0;
        for (int k = 1; k <= 8; k++) begin
          if (!f && r[(m_ptr + k) % 8]) begin
            w = (m_ptr + k) % 8;
            f = 1;
          end
        end
        m_busy = 1;
        m_sel  = w;
        m_cnt  = 0;
      end
    end else if (!r[m_sel]) begin
      m_ptr  = m_sel;
      m_busy = 0;
    end else if (rd) begin
      m_cnt = m_cnt + 1;
      if (l[m_sel] || m_cnt == MAXB) begin
        m_ptr  = m_sel;
        m_busy = 0;
      end
    end
  endtask

  initial begin
    int xfers;
    logic [4:0] rdy_seq;
    logic [7:0] eg;
    logic       ev;

    tbl[0]  = '{8'h81, 8'h00, 1'b1, 3'd0, 8'h01, 1'b1, 1'b1};
    tbl[1]  = '{8'h81, 8'h01, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{8'h80, 8'h00, 1'b1, 3'd7, 8'h80, 1'b1, 1'b1};
    tbl[3]  = '{8'h80, 8'h00, 1'b0, 3'd7, 8'h80, 1'b1, 1'b1};
    tbl[4]  = '{8'h80, 8'h00, 1'b1, 3'd7, 8'h80, 1'b1, 1'b1};
    tbl[5]  = '{8'h80, 8'h00, 1'b1, 3'd7, 8'h80, 1'b1, 1'b1};
    tbl[6]  = '{8'h80, 8'h00, 1'b1, 3'd7, 8'h80, 1'b1, 1'b1};
    tbl[7]  = '{8'h80, 8'h00, 1'b1, 3'd7, 8'h00, 1'b0, 1'b0};
    tbl[8]  = '{8'hA0, 8'h00, 1'b1, 3'd5, 8'h20, 1'b1, 1'b1};
    tbl[9]  = '{8'h80, 8'h00, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0};
    tbl[10] = '{8'h00, 8'h00, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0};
    tbl[11] = '{8'h08, 8'h08, 1'b0, 3'd3, 8'h08, 1'b1, 1'b1};
    tbl[12] = '{8'h08, 8'h08, 1'b1, 3'd3, 8'h00, 1'b0, 1'b0};
    tbl[13] = '{8'h18, 8'h18, 1'b1, 3'd4, 8'h10, 1'b1, 1'b1};
    tbl[14] = '{8'h18, 8'h18, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0};
    tbl[15] = '{8'h18, 8'h18, 1'b1, 3'd3, 8'h08, 1'b1, 1'b1};
    tbl[16] = '{8'h00, 8'h00, 1'b1, 3'd3, 8'h00, 1'b0, 1'b0};

    rst       = 1'b1;
    req       = '0;
    last      = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 3'd0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;

    // vector table; ptr starts at 7 so entry 0 is the wrap case
    for (int i = 0; i < 17; i++) begin
      req       = tbl[i].req;
      last      = tbl[i].last;
      out_ready = tbl[i].rdy;
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].sel,
              tbl[i].gnt, tbl[i].busy, tbl[i].valid);
    end

    // asynchronous reset in the middle of a burst
    req       = 8'h40;
    last      = 8'h00;
    out_ready = 1'b1;
    tick();
    chk_out("rstmid.grant", 3'd6, 8'h40, 1'b1, 1'b1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk_out("rstmid.async", 3'd0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    req = 8'h01;
    tick();
    chk_out("rstmid.regrant", 3'd0, 8'h01, 1'b1, 1'b1);

    // fairness: everyone requesting, single-beat bursts
    req  = 8'hFF;
    last = 8'hFF;
    tick();
    chk_out("fair.rel0", 3'd0, 8'h00, 1'b0, 1'b0);
    for (int g = 1; g <= 8; g++) begin
      tick();
      eg = 8'h01 << (g % 8);
      chk_out($sformatf("fair.g%0d", g), 3'(g % 8), eg,
              1'b1, 1'b1);
      tick();
      chk_out($sformatf("fair.r%0d", g), 3'(g % 8),
              8'h00, 1'b0, 1'b0);
    end

    // burst with stalls, last on third transfer
    req     = 8'h08;
    last    = 8'h00;
    tick();
    chk_out("stall.grant", 3'd3, 8'h08, 1'b1, 1'b1);
    rdy_seq = 5'b10101;
    xfers   = 0;
    for (int i = 0; i < 5; i++) begin
      out_ready = rdy_seq[i];
      last      = (i == 4) ? 8'h08 : 8'h00;
      if (out_valid && out_ready) xfers++;
      tick();
      if (i < 4)
        chk_out($sformatf("stall.c%0d", i), 3'd3, 8'h08,
                1'b1, 1'b1);
      else
        chk_out("stall.rel", 3'd3, 8'h00, 1'b0, 1'b0);
    end
    chk("stall.beats", 32'(xfers), 32'd3);

    // abort after two beats, pending 1 wins next
    req       = 8'h42;
    last      = 8'h00;
    out_ready = 1'b1;
    tick();
    chk_out("abort.grant", 3'd6, 8'h40, 1'b1, 1'b1);
    tick();
    tick();
    chk_out("abort.beat2", 3'd6, 8'h40, 1'b1, 1'b1);
    req = 8'h02;
    tick();
    chk_out("abort.rel", 3'd6, 8'h00, 1'b0, 1'b0);
    tick();
    chk_out("abort.next", 3'd1, 8'h02, 1'b1, 1'b1);

    // randomized run against the reference model
    req = 8'h00;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    @(negedge clk);
    m_busy = 0;
    m_sel  = 0;
    m_ptr  = 7;
    m_cnt  = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      last      = ($urandom_range(0, 3) == 0) ?
                  8'($urandom) : 8'h00;
      out_ready = ($urandom_range(0, 2) != 0);
      model_step(req, last, out_ready);
      tick();
      eg = (m_busy != 0) ? (8'h01 << m_sel) : 8'h00;
      ev = (m_busy != 0) && req[m_sel];
      chk_out($sformatf("rand%0d", c), 3'(m_sel), eg,
              1'(m_busy), ev);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
